// File: rtl/pipeline_chain_if.sv
// pipeline_chain_if -- bundle of every pipeline_chain signal except clock and reset.
//
// Parameters DATA_W / STAGES / CNT_W must match the pipeline_chain instance.
//   i_in_valid / i_in_data / o_in_ready   : upstream handshake into stage 0
//   i_stall[k] / i_flush[k]               : per-stage hold / kill requests
//   o_out_valid / o_out_data / i_out_ready: downstream handshake from the last stage
//   o_stage_valid / o_stage_data          : per-stage debug view (stage k at [k*DATA_W +: DATA_W])
//   o_occupancy                           : registered count of valid stages
//   o_stall_cnt                           : saturating blocked-cycle counter
//   i_dbg_mode / i_dbg_step               : debug freeze and single-advance pulse
// master = the environment driving the pipeline, slave = the pipeline itself.
interface pipeline_chain_if #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
);
  logic                     i_in_valid;
  logic [DATA_W-1:0]        i_in_data;
  logic                     o_in_ready;
  logic [STAGES-1:0]        i_stall;
  logic [STAGES-1:0]        i_flush;
  logic                     o_out_valid;
  logic [DATA_W-1:0]        o_out_data;
  logic                     i_out_ready;
  logic [STAGES-1:0]        o_stage_valid;
  logic [STAGES*DATA_W-1:0] o_stage_data;
  logic [3:0]               o_occupancy;
  logic [CNT_W-1:0]         o_stall_cnt;
  logic                     i_dbg_mode;
  logic                     i_dbg_step;

  modport master (
    output i_in_valid, i_in_data, i_stall, i_flush, i_out_ready, i_dbg_mode, i_dbg_step,
    input  o_in_ready, o_out_valid, o_out_data, o_stage_valid, o_stage_data,
           o_occupancy, o_stall_cnt
  );

  modport slave (
    input  i_in_valid, i_in_data, i_stall, i_flush, i_out_ready, i_dbg_mode, i_dbg_step,
    output o_in_ready, o_out_valid, o_out_data, o_stage_valid, o_stage_data,
           o_occupancy, o_stall_cnt
  );
endinterface

// File: rtl/pipeline_chain.sv
// pipeline_chain -- STAGES-deep valid/ready register chain with per-stage
// stall and flush, a registered occupancy count and a saturating counter of
// cycles in which some valid word could not move.
//
// Ports:
//   i_clk : sole clock, rising edge
//   i_rst : synchronous active-high reset (overrides stall, flush and debug)
//   bus   : pipeline_chain_if.slave carrying all data/handshake/debug signals
//
// Optional feature: define PIPELINE_CHAIN_DBG_EN to compile in debug freeze.
// While i_dbg_mode=1 every ready (including the output handshake) is forced
// low except on cycles with i_dbg_step=1; flush and reset still act, and
// frozen cycles are not counted. Without the macro the debug inputs are ignored.
module pipeline_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pipeline_chain_if.slave  bus
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [3:0]        occupancy_q, occupancy_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [STAGES:0]   ready;
  logic [STAGES-1:0] adv_out;
  logic [STAGES-1:0] src_valid;
  logic [DATA_W-1:0] src_data [STAGES];
  logic              freeze;
  logic              blocked;

`ifdef PIPELINE_CHAIN_DBG_EN
  assign freeze = bus.i_dbg_mode && !bus.i_dbg_step;
`else
  assign freeze = 1'b0;
  logic unused_dbg;
  assign unused_dbg = bus.i_dbg_mode ^ bus.i_dbg_step;
`endif

  // Ready ripples from the output back to stage 0 in one cycle, so a stage
  // whose successor is draining can accept in the same cycle (full throughput).
  // A stalled stage neither accepts nor releases its word.
  always_comb begin
    ready          = '0;
    adv_out        = '0;
    ready[STAGES]  = bus.i_out_ready && !freeze;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_out[k] = valid_q[k] && !bus.i_stall[k] && ready[k+1];
      ready[k]   = !freeze && !bus.i_stall[k] && (!valid_q[k] || adv_out[k]);
    end
  end

  // Word offered to each stage: upstream input for stage 0, otherwise the
  // previous stage, which shows a bubble while it is stalled.
  assign src_valid   = {valid_q[STAGES-2:0] & ~bus.i_stall[STAGES-2:0], bus.i_in_valid};
  assign src_data[0] = bus.i_in_data;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_src
      assign src_data[gi] = data_q[gi-1];
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      // Flush wins over everything, including a word arriving this cycle.
      if (bus.i_flush[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
      end else if (ready[k]) begin
        valid_d[k] = src_valid[k];
        data_d[k]  = src_valid[k] ? src_data[k] : '0;
      end
    end

    occupancy_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy_d = occupancy_d + 4'(valid_d[k]);
    end

    blocked     = (|(valid_q & ~adv_out)) && !freeze;
    stall_cnt_d = stall_cnt_q;
    if (blocked && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign bus.o_in_ready    = ready[0];
  assign bus.o_out_valid   = valid_q[STAGES-1];
  assign bus.o_out_data    = data_q[STAGES-1];
  assign bus.o_stage_valid = valid_q;
  assign bus.o_occupancy   = occupancy_q;
  assign bus.o_stall_cnt   = stall_cnt_q;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_dbg_data
      assign bus.o_stage_data[gi*DATA_W +: DATA_W] = data_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_chain.sv
// tb_pipeline_chain -- self-checking bench for pipeline_chain.
// Main DUT: STAGES=4, DATA_W=32, CNT_W=16. A second DUT (STAGES=2, CNT_W=3)
// exercises counter saturation. Output words are checked through a queue
// filled when the bench hands a word to stage 0; cycle-exact expectations
// for streaming and stall-bubble come from a vector table.
module tb_pipeline_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  pipeline_chain_if #(.DATA_W(32), .STAGES(4), .CNT_W(16)) bus ();
  pipeline_chain_if #(.DATA_W(32), .STAGES(2), .CNT_W(3))  bus2 ();

  pipeline_chain #(.DATA_W(32), .STAGES(4), .CNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  pipeline_chain #(.DATA_W(32), .STAGES(2), .CNT_W(3)) dut2 (
    .i_clk (clk),
    .i_rst (rst2),
    .bus   (bus2.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  st;
    logic [3:0]  fl;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [3:0]  e_sv;
    logic [3:0]  e_occ;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: pop on an output handshake, push on an accepted input that is not killed.
  task automatic sb_update();
    logic [31:0] e;
    if (!rst) begin
      if (bus.o_out_valid && bus.i_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra actual=%0h required=none", bus.o_out_data);
        end else begin
          e = exp_q.pop_front();
          $display("xfer out data=%08h expected=%08h", bus.o_out_data, e);
          chk("sb_data", bus.o_out_data, e);
        end
      end
      if (bus.i_in_valid && bus.o_in_ready && !bus.i_flush[0]) exp_q.push_back(bus.i_in_data);
    end
  endtask

  // Called just after a falling edge: apply inputs, settle, run the scoreboard.
  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] st,
                       input logic [3:0] fl, input logic ordy,
                       input logic dm = 1'b0, input logic ds = 1'b0);
    bus.i_in_valid  = v;
    bus.i_in_data   = d;
    bus.i_stall     = st;
    bus.i_flush     = fl;
    bus.i_out_ready = ordy;
    bus.i_dbg_mode  = dm;
    bus.i_dbg_step  = ds;
    #1;
    sb_update();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1);
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // Streaming 0x11,0x22,0x33 (rows 0-7), then a one-cycle stall of stage 1 (rows 8-17).
    tbl[0]  = '{1'b1, 32'h11, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0000, 4'd0, 16'd0};
    tbl[1]  = '{1'b1, 32'h22, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0001, 4'd1, 16'd0};
    tbl[2]  = '{1'b1, 32'h33, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0011, 4'd2, 16'd0};
    tbl[3]  = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0111, 4'd3, 16'd0};
    tbl[4]  = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h11, 4'b1110, 4'd3, 16'd0};
    tbl[5]  = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h22, 4'b1100, 4'd2, 16'd0};
    tbl[6]  = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h33, 4'b1000, 4'd1, 16'd0};
    tbl[7]  = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0000, 4'd0, 16'd0};
    tbl[8]  = '{1'b1, 32'h0A, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0000, 4'd0, 16'd0};
    tbl[9]  = '{1'b1, 32'h0B, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0001, 4'd1, 16'd0};
    tbl[10] = '{1'b1, 32'h0C, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 32'h00, 4'b0011, 4'd2, 16'd0};
    tbl[11] = '{1'b1, 32'h0C, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0011, 4'd2, 16'd1};
    tbl[12] = '{1'b1, 32'h0D, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0111, 4'd3, 16'd1};
    tbl[13] = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h0A, 4'b1111, 4'd4, 16'd1};
    tbl[14] = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h0B, 4'b1110, 4'd3, 16'd1};
    tbl[15] = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h0C, 4'b1100, 4'd2, 16'd1};
    tbl[16] = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h0D, 4'b1000, 4'd1, 16'd1};
    tbl[17] = '{1'b0, 32'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h00, 4'b0000, 4'd0, 16'd1};

    bus2.i_in_valid = 1'b0; bus2.i_in_data = 32'h0; bus2.i_stall = 2'b00; bus2.i_flush = 2'b00;
    bus2.i_out_ready = 1'b0; bus2.i_dbg_mode = 1'b0; bus2.i_dbg_step = 1'b0;

    // Reset state, with stall/flush/debug inputs active during reset.
    @(negedge clk);
    drive(1'b1, 32'hDEAD, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1);
    chk("rst_stage_valid", bus.o_stage_valid, 4'b0000);
    chk("rst_stage_data", bus.o_stage_data, 128'h0);
    chk("rst_out_valid", bus.o_out_valid, 1'b0);
    chk("rst_occupancy", bus.o_occupancy, 4'd0);
    chk("rst_stall_cnt", bus.o_stall_cnt, 16'd0);
    chk("rst_in_ready", bus.o_in_ready, 1'b1);
    tick();

    // Table: streaming and stall bubble.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].st, tbl[i].fl, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), bus.o_in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_out_valid", i), bus.o_out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_out_data", i), bus.o_out_data, tbl[i].e_od);
      chk($sformatf("tbl%0d_stage_valid", i), bus.o_stage_valid, tbl[i].e_sv);
      chk($sformatf("tbl%0d_occupancy", i), bus.o_occupancy, tbl[i].e_occ);
      chk($sformatf("tbl%0d_stall_cnt", i), bus.o_stall_cnt, tbl[i].e_cnt);
      if (i == 11) chk("bubble_stage_data", bus.o_stage_data, {32'h0, 32'h0, 32'h0A, 32'h0B});
      tick();
    end
    chk("table_sb_empty", exp_q.size(), 0);

    // Flush of stage 0 while 0xBEEF is offered.
    drive(1'b1, 32'hBEEF, 4'h0, 4'h1, 1'b1);
    chk("flush0_in_ready", bus.o_in_ready, 1'b1);
    tick();
    drive(1'b1, 32'h0202, 4'h0, 4'h0, 1'b1);
    chk("flush0_stage_valid", bus.o_stage_valid, 4'b0000);
    chk("flush0_stage_data", bus.o_stage_data, 128'h0);
    tick();
    drain();

    // Independent flushes of stages 1 and 3 in a full, blocked pipe.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h31 + i, 4'h0, 4'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 4'h0, 4'b1010, 1'b0);
    chk("mflush_full", bus.o_stage_valid, 4'b1111);
    tick();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
    chk("mflush_stage_valid", bus.o_stage_valid, 4'b0101);
    chk("mflush_stage_data", bus.o_stage_data, {32'h0, 32'h32, 32'h0, 32'h34});
    exp_q.delete(2);
    exp_q.delete(0);
    tick();
    drain();

    // Stall and flush together on stage 2.
    do_reset();
    drive(1'b1, 32'h41, 4'h0, 4'h0, 1'b1); tick();
    drive(1'b1, 32'h42, 4'h0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 4'b0100, 4'b0100, 1'b1);
    chk("sf_pre_stage_valid", bus.o_stage_valid, 4'b0110);
    tick();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1);
    chk("sf_stage_valid", bus.o_stage_valid, 4'b0010);
    chk("sf_stage_data", bus.o_stage_data, {32'h0, 32'h0, 32'h42, 32'h0});
    chk("sf_stall_cnt", bus.o_stall_cnt, 16'd1);
    exp_q.delete(0);
    tick();
    drain();

    // Back-pressure: full pipe held for 10 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h51 + i, 4'h0, 4'h0, 1'b0);
      chk($sformatf("bp_fill%0d_in_ready", i), bus.o_in_ready, 1'b1);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h55, 4'h0, 4'h0, 1'b0);
      chk($sformatf("bp_hold%0d_in_ready", i), bus.o_in_ready, 1'b0);
      tick();
    end
    drive(1'b1, 32'h55, 4'h0, 4'h0, 1'b1);
    chk("bp_stall_cnt", bus.o_stall_cnt, 16'd10);
    chk("bp_release_in_ready", bus.o_in_ready, 1'b1);
    tick();
    drain();
    chk("bp_stall_cnt_after", bus.o_stall_cnt, 16'd10);

    do_reset();
    drive(1'b1, 32'h61, 4'h0, 4'h0, 1'b1); tick();
    drive(1'b1, 32'h62, 4'h0, 4'h0, 1'b1); tick();
`ifdef PIPELINE_CHAIN_DBG_EN
    // Frozen: nothing moves except on the three step cycles.
    begin
      logic [3:0] sv_before [3];
      sv_before[0] = 4'b0011;
      sv_before[1] = 4'b0110;
      sv_before[2] = 4'b1100;
      for (int n = 0; n < 3; n++) begin
        for (int f = 0; f < 2; f++) begin
          drive(1'b1, 32'h77, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
          chk($sformatf("dbg_step%0d_hold%0d_sv", n, f), bus.o_stage_valid, sv_before[n]);
          chk($sformatf("dbg_step%0d_hold%0d_in_ready", n, f), bus.o_in_ready, 1'b0);
          tick();
        end
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        tick();
      end
      drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      chk("dbg_after_steps_sv", bus.o_stage_valid, 4'b1000);
      chk("dbg_after_steps_out_data", bus.o_out_data, 32'h62);
      chk("dbg_frozen_stall_cnt", bus.o_stall_cnt, 16'd0);
      tick();
    end
`else
    // Debug inputs are ignored in this build.
    drive(1'b1, 32'h63, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("nodbg_in_ready", bus.o_in_ready, 1'b1);
    chk("nodbg_stage_valid", bus.o_stage_valid, 4'b0011);
    tick();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("nodbg_advanced", bus.o_stage_valid, 4'b0111);
    tick();
`endif
    // Reset in the middle of a blocked stream.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h70 + i, 4'h0, 4'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
    chk("midrst_pre_cnt_nonzero", bus.o_stall_cnt != 16'd0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 32'h99, 4'h5, 4'h2, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    exp_q.delete();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1);
    chk("midrst_stage_valid", bus.o_stage_valid, 4'b0000);
    chk("midrst_stage_data", bus.o_stage_data, 128'h0);
    chk("midrst_out_valid", bus.o_out_valid, 1'b0);
    chk("midrst_out_data", bus.o_out_data, 32'h0);
    chk("midrst_occupancy", bus.o_occupancy, 4'd0);
    chk("midrst_stall_cnt", bus.o_stall_cnt, 16'd0);
    chk("midrst_in_ready", bus.o_in_ready, 1'b1);
    tick();

    // Saturation on the 2-stage, 3-bit-counter instance.
    rst2 = 1'b0;
    bus2.i_in_valid = 1'b1;
    bus2.i_in_data  = 32'h71;
    tick();
    bus2.i_in_valid = 1'b0;
    bus2.i_in_data  = 32'h0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("sat_cnt_5", bus2.o_stall_cnt, 3'd5);
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("sat_cnt_max", bus2.o_stall_cnt, 3'd7);
    tick();
    #1;
    chk("sat_cnt_hold", bus2.o_stall_cnt, 3'd7);
    chk("sat_out_valid", bus2.o_out_valid, 1'b1);
    chk("sat_out_data", bus2.o_out_data, 32'h71);
    chk("sat_in_ready", bus2.o_in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_chain.md
PIPELINE_CHAIN -- requirements
Module: pipeline_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width per stage.
REQ-002 SHALL have parameter STAGES, default 4, legal range 2..8: number of pipeline registers.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-004 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_in_valid, input, 1: upstream offers a word.
REQ-007 SHALL have port i_in_data, input, DATA_W: upstream word.
REQ-008 SHALL have port o_in_ready, output, 1: stage 0 accepts this cycle.
REQ-009 SHALL have port i_stall, input, STAGES: bit k is the hold request for stage k.
REQ-010 SHALL have port i_flush, input, STAGES: bit k is the kill request for stage k.
REQ-011 SHALL have port o_out_valid, output, 1: last stage valid.
REQ-012 SHALL have port o_out_data, output, DATA_W: last stage data.
REQ-013 SHALL have port i_out_ready, input, 1: downstream consumes.
REQ-014 SHALL have port o_stage_valid, output, STAGES: per-stage valid, for debug.
REQ-015 SHALL have port o_stage_data, output, STAGES*DATA_W: stage k at [k*DATA_W +: DATA_W].
REQ-016 SHALL have port o_occupancy, output, 4: count of valid stages.
REQ-017 SHALL have port o_stall_cnt, output, CNT_W: saturating blocked-cycle counter.
REQ-018 SHALL have port i_dbg_mode, input, 1: freeze request.
REQ-019 SHALL have port i_dbg_step, input, 1: single-advance pulse.

Function
REQ-020 SHALL compute adv_out(k) = valid_k && ready(k+1); ready(STAGES) = i_out_ready.
REQ-021 SHALL compute ready(k) = !i_stall[k] && (!valid_k || adv_out(k)); o_in_ready = ready(0).
REQ-022 SHALL let ready be a combinational chain with no registered slack, giving a 1-word-per-cycle throughput and a STAGES-cycle latency in to out.
REQ-023 SHALL load stage k on a rising edge when ready(k): valid_k <= valid_(k-1) (i_in_valid for k=0), data_k <= incoming data if that is valid, else 0.
REQ-024 SHALL hold valid_k and data_k unchanged when !ready(k) and the stage is not flushed.
REQ-025 SHALL make a stalled stage k hold its contents, back-pressure stages 0..k-1, and deliver a bubble (valid=0, data=0) to stage k+1 on the next edge.
REQ-026 SHALL on i_flush[k] set valid_k <= 0 and data_k <= 0 at the next edge; any word advanced from stage k-1 in that cycle is discarded.
REQ-027 SHALL give flush priority over stall; if both are set on stage k, stage k is cleared and ready(k) stays 0.
REQ-028 SHALL allow flushes on several stages at once, each independent.
REQ-029 SHALL count o_stall_cnt +1 per cycle where any valid_k && !adv_out(k); the count saturates at 2^CNT_W-1.
REQ-030 SHALL register o_occupancy as the popcount of the next-state valid bits.

Reset
REQ-031 SHALL on i_rst at a rising edge clear all valid bits, data, o_occupancy and o_stall_cnt to 0, overriding stall, flush and debug inputs.
REQ-032 SHALL give o_in_ready = 1 from the first cycle after reset while i_stall[0] = 0 and freeze is inactive.
REQ-033 SHALL discard all in-flight words when reset is asserted mid-operation, with no partial outputs.

Configuration
REQ-034 SHALL use the macro PIPELINE_CHAIN_DBG_EN to compile in debug freeze.
REQ-035 SHALL, when PIPELINE_CHAIN_DBG_EN is defined and i_dbg_mode = 1, force ready(k) = 0 for every k except on cycles with i_dbg_step = 1; those cycles behave as normal mode. Flush and reset stay effective while frozen, and o_stall_cnt does not count frozen cycles.
REQ-036 SHALL, when PIPELINE_CHAIN_DBG_EN is undefined, ignore i_dbg_mode and i_dbg_step, with the ports kept.

Verification
REQ-037 SHALL cover streaming: STAGES=4, in 0x11,0x22,0x33 on consecutive cycles, i_out_ready=1 -> o_out_data 0x11,0x22,0x33 on cycles 4,5,6; o_occupancy peaks at 3.
REQ-038 SHALL cover a stall bubble: i_stall[1]=1 for 1 cycle while stage1 holds 0xA -> stage1 keeps 0xA, stage2 gets valid=0 data=0, o_in_ready=0 if stage0 is full, and the stream resumes in order.
REQ-039 SHALL cover a flush: i_flush[0]=1 while i_in_valid=1 with 0xBEEF -> 0xBEEF never appears at the output and stage0 reads valid=0 next cycle.
REQ-040 SHALL cover stall+flush: i_stall[2]=i_flush[2]=1 -> stage2 is cleared, stage1 holds, and o_stall_cnt increments.
REQ-041 SHALL cover back-pressure: i_out_ready=0 for 10 cycles with a full pipe -> o_in_ready=0, o_stall_cnt=10 (CNT_W=16), and no data loss after release.
REQ-042 SHALL cover debug and reset: with the macro defined, i_dbg_mode=1 plus 3 i_dbg_step pulses -> exactly 3 advances; then i_rst mid-stream -> all outputs 0 next cycle.
